// File: rtl/shift_add_multiplier_32bit.sv
// Sequential 32x32 -> 64-bit unsigned shift-and-add multiplier.
// One partial-product step per clock through a 32-bit ripple-carry adder;
// start/ready/done handshake, one multiply in flight at a time.

// Combinational 32-bit ripple-carry adder with carry-out and signed overflow.
module full_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow
);
  logic [32:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout     = carry[32];
  assign overflow = carry[32] ^ carry[31];
endmodule

module shift_add_multiplier_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_reg;
  logic [31:0] m_reg;
  logic [31:0] p_hi_reg;
  logic [31:0] p_lo_reg;
  logic [5:0]  cnt_reg;

  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        adder_overflow_unused;

  // The multiplicand is added only when the current multiplier bit is set.
  assign add_b = p_lo_reg[0] ? m_reg : 32'h0;

  full_adder_32bit u_adder (
    .a        (p_hi_reg),
    .b        (add_b),
    .cin      (1'b0),
    .sum      (add_sum),
    .cout     (add_cout),
    .overflow (adder_overflow_unused)
  );

  // Control FSM and datapath registers; the carry-out shifts into bit 63.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      m_reg     <= 32'h0;
      p_hi_reg  <= 32'h0;
      p_lo_reg  <= 32'h0;
      cnt_reg   <= 6'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            m_reg     <= a_in;
            p_lo_reg  <= b_in;
            p_hi_reg  <= 32'h0;
            cnt_reg   <= 6'd0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          {p_hi_reg, p_lo_reg} <= {add_cout, add_sum, p_lo_reg[31:1]};
          cnt_reg              <= cnt_reg + 6'd1;
          if (cnt_reg == 6'd31) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready   = (state_reg == IDLE);
  assign busy    = (state_reg == BUSY) || (state_reg == DONE);
  assign done    = (state_reg == DONE);
  assign product = {p_hi_reg, p_lo_reg};
endmodule

// File: tb/tb_shift_add_multiplier_32bit.sv
// Testbench for shift_add_multiplier_32bit: cycle-level behavioural model
// checked every cycle, plus directed literal expectations.
module tb_shift_add_multiplier_32bit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] product;

  shift_add_multiplier_32bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: -1 = idle, 0..31 = cycles spent computing, 32 = result cycle.
  int          phase      = -1;
  bit          synced     = 1'b0;
  bit          prod_valid = 1'b1;
  logic [63:0] exp_prod   = 64'h0;
  logic [63:0] pend       = 64'h0;
  int          cyc        = 0;
  int          done_cyc[$];

  // Advance the model on every rising edge using the inputs presented to it.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      synced     = 1'b1;
      phase      = -1;
      exp_prod   = 64'h0;
      prod_valid = 1'b1;
    end else if (phase == -1) begin
      if (start) begin
        phase      = 0;
        pend       = 64'(a_in) * 64'(b_in);
        prod_valid = 1'b0;
      end
    end else if (phase < 31) begin
      phase++;
    end else if (phase == 31) begin
      phase      = 32;
      exp_prod   = pend;
      prod_valid = 1'b1;
    end else begin
      phase = -1;
    end
  end

  // Compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (synced) begin
      check("ready", 64'(ready), 64'(phase == -1));
      check("busy",  64'(busy),  64'(phase >= 0));
      check("done",  64'(done),  64'(phase == 32));
      if (prod_valid) check("product", product, exp_prod);
      if (done) begin
        done_cyc.push_back(cyc);
        $display("txn cycle %0d: product=%h", cyc, product);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issue one multiply, wait for done with a bound, check latency and result.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int waited;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    a_in  = 32'hDEAD_BEEF;
    b_in  = 32'hCAFE_F00D;
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      waited++;
      if (done) break;
    end
    check({name, "_done_seen"}, 64'(done), 64'd1);
    check({name, "_latency"}, 64'(waited), 64'd33);
    check({name, "_result"}, product, exp);
    @(negedge clk);
    check({name, "_ready_after"}, 64'(ready), 64'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a_in  = 32'h0;
    b_in  = 32'h0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_product", product, 64'h0);
    check("reset_ready", 64'(ready), 64'd1);

    run_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
    run_op("max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("msb_x2", 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000);
    run_op("zero", 32'h0, 32'h1234_5678, 64'h0);

    // start held high with operands changing every cycle
    done_cyc.delete();
    start = 1'b1;
    for (int i = 0; i < 111; i++) begin
      a_in = 32'(i * 7 + 1);
      b_in = 32'hF000_0000 + 32'(i);
      step();
    end
    start = 1'b0;
    repeat (40) step();
    check("held_done_count", 64'(done_cyc.size()), 64'd4);
    for (int i = 1; i < done_cyc.size(); i++) begin
      check("held_spacing", 64'(done_cyc[i] - done_cyc[i-1]), 64'd34);
    end

    // reset at iteration 10 of 7x9
    a_in  = 32'd7;
    b_in  = 32'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_product", product, 64'h0);
    run_op("7x9", 32'd7, 32'd9, 64'd63);

    // reset and start on the same edge
    rst   = 1'b1;
    start = 1'b1;
    a_in  = 32'd5;
    b_in  = 32'd5;
    step();
    rst   = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_start_busy", 64'(busy), 64'd0);
    end
    check("rst_start_product", product, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
